// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects through the enabled channels,
// dwells on each so the mux settles, and publishes the captured y bits as a frame.
module mux4_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [3:0] en_mask,
    input  logic       y,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic [3:0] sample,
    output logic       sample_valid
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    state_t        state, state_nx;
    logic [1:0]    ch, ch_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    mask_q, mask_nx;
    logic [3:0]    shadow, shadow_nx;
    logic [3:0]    sample_nx;
    logic          valid_nx;
    logic [3:0]    captured;
    logic [3:0]    above;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign {s1, s0} = ch;
    assign busy     = (state == SCAN);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx  = state;
        ch_nx     = ch;
        cnt_nx    = cnt;
        mask_nx   = mask_q;
        shadow_nx = shadow;
        sample_nx = sample;
        valid_nx  = 1'b0;
        captured  = shadow;
        captured[ch] = y;
        above     = 4'b1110 << ch;

        case (state)
            IDLE: begin
                if (start && (en_mask != 4'b0000)) begin
                    mask_nx   = en_mask;
                    shadow_nx = 4'b0000;
                    ch_nx     = lowest(en_mask);
                    cnt_nx    = '0;
                    state_nx  = SCAN;
                end
            end
            SCAN: begin
                if (cnt != LAST) begin
                    cnt_nx = cnt + CW'(1);
                end else begin
                    shadow_nx = captured;
                    if ((mask_q & above) != 4'b0000) begin
                        ch_nx  = lowest(mask_q & above);
                        cnt_nx = '0;
                    end else begin
                        // Frame end; bits of disabled channels are forced to 0.
                        sample_nx = captured & mask_q;
                        valid_nx  = 1'b1;
                        if (cont && (en_mask != 4'b0000)) begin
                            mask_nx   = en_mask;
                            shadow_nx = 4'b0000;
                            ch_nx     = lowest(en_mask);
                            cnt_nx    = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ch           <= 2'd0;
            cnt          <= '0;
            mask_q       <= 4'b0000;
            shadow       <= 4'b0000;
            sample       <= 4'b0000;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            ch           <= ch_nx;
            cnt          <= cnt_nx;
            mask_q       <= mask_nx;
            shadow       <= shadow_nx;
            sample       <= sample_nx;
            sample_valid <= valid_nx;
        end
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: a behavioural mux drives y, and expected
// frame words are queued at frame start and popped when sample_valid pulses.
module tb_mux4_scan_ctrl;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] en_mask = 4'b0000;
    logic [3:0] a = 4'b0000;
    logic       y;
    logic       s0, s1, busy, sample_valid;
    logic [3:0] sample;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    assign y = a[{s1, s0}];

    mux4_scan_ctrl #(.DWELL(DWELL), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .en_mask(en_mask),
        .y(y), .s0(s0), .s1(s1), .busy(busy), .sample(sample),
        .sample_valid(sample_valid)
    );

    // Scoreboard: every sample_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: sample=%b with no frame expected", sample);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (sample !== e) begin
                    fails++;
                    $display("FAIL frame_word: got %b expected %b", sample, e);
                end
            end
        end
    end

    // Drives one frame from IDLE and checks selects/busy every cycle; optionally
    // pulses start at cycle 'poke' to confirm it is ignored while busy.
    task automatic run_frame(input logic [3:0] mask, input logic [3:0] av, input int poke);
        int ch_list[4];
        int n = 0;
        for (int b = 0; b < 4; b++) if (mask[b]) begin ch_list[n] = b; n++; end
        @(negedge clk);
        a = av;
        en_mask = mask;
        start = 1'b1;
        exp_q.push_back(av & mask);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n * DWELL; i++) begin
            tests++;
            if ({s1, s0} !== 2'(ch_list[i / DWELL]) || busy !== 1'b1 || sample_valid !== 1'b0) begin
                fails++;
                $display("FAIL frame_cycle%0d: sel=%b busy=%b valid=%b expected sel=%0d busy=1 valid=0",
                         i, {s1, s0}, busy, sample_valid, ch_list[i / DWELL]);
            end
            if (i == poke) start = 1'b1;
            if (i == poke + 1) start = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0 || sample_valid !== 1'b1 || {s1, s0} !== 2'(ch_list[n - 1])) begin
            fails++;
            $display("FAIL frame_end: busy=%b valid=%b sel=%b expected busy=0 valid=1 sel=%0d",
                     busy, sample_valid, {s1, s0}, ch_list[n - 1]);
        end
        @(negedge clk);
        tests++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || {s1, s0} !== 2'(ch_list[n - 1])) begin
            fails++;
            $display("FAIL idle_hold: valid=%b busy=%b sel=%b expected valid=0 busy=0 sel=%0d",
                     sample_valid, busy, {s1, s0}, ch_list[n - 1]);
        end
    endtask

    task automatic check_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL %s: busy=%b expected 0 at cycle %0d", name, busy, i);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        en_mask = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if ({s1, s0, busy, sample, sample_valid} !== 8'b0) begin
                fails++;
                $display("FAIL reset: s1s0=%b busy=%b sample=%b valid=%b expected all 0",
                         {s1, s0}, busy, sample, sample_valid);
            end
        end
        rst = 1'b0;
        start = 1'b0;
        check_quiet("reset_release", 2);
    endtask

    task automatic test_full_scan();
        run_frame(4'hF, 4'b1010, -1);
    endtask

    task automatic test_sparse();
        run_frame(4'b0101, 4'b1111, -1);
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        en_mask = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_quiet("zero_mask_start", 6);
        run_frame(4'hF, 4'b0110, 5);
    endtask

    task automatic test_continuous();
        @(negedge clk);
        a = 4'b0011;
        en_mask = 4'hF;
        cont = 1'b1;
        start = 1'b1;
        exp_q.push_back(4'b0011);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tests++;
            if (busy !== 1'b1 || sample_valid !== ((i == 16) || (i == 32)) ||
                {s1, s0} !== 2'((i % 16) / DWELL)) begin
                fails++;
                $display("FAIL cont_cycle%0d: busy=%b valid=%b sel=%b expected busy=1 sel=%0d",
                         i, busy, sample_valid, {s1, s0}, (i % 16) / DWELL);
            end
            if (i == 16) begin a = 4'b1100; exp_q.push_back(4'b1100); end
            if (i == 32) begin a = 4'b1001; exp_q.push_back(4'b1001); end
            if (i == 40) cont = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0 || sample_valid !== 1'b1) begin
            fails++;
            $display("FAIL cont_stop: busy=%b valid=%b expected busy=0 valid=1", busy, sample_valid);
        end
        check_quiet("cont_after_stop", 20);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        a = 4'hF;
        en_mask = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({s1, s0, busy, sample, sample_valid} !== 8'b0) begin
            fails++;
            $display("FAIL reset_mid: s1s0=%b busy=%b sample=%b valid=%b expected all 0",
                     {s1, s0}, busy, sample, sample_valid);
        end
        rst = 1'b0;
        check_quiet("after_abort", 20);
        run_frame(4'hF, 4'b0110, -1);
        run_frame(4'b1000, 4'b1000, -1);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_ignored_start();
        test_continuous();
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_frames: %0d expected frames never published, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
- Sequencer that sits around a 4:1 mux with inputs a0..a3, selects s1/s0 and output y.
- Drives s1/s0 through the enabled channels in ascending order.
- Holds each select for DWELL cycles so the mux path settles, then samples y into a 4-bit frame word.
- Publishes the frame word with a one-cycle valid pulse; supports single-shot and continuous scanning.

Parameters:
- DWELL, 4, cycles each select is held before y is sampled; legal range 1..255.
- CW, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to begin a frame
- cont  in  1  continuous mode; when high at end of frame, the next frame begins immediately
- en_mask  in  4  channel enables, bit i = channel i
- y  in  1  mux output, sampled by this block
- s0  out  1  mux select LSB
- s1  out  1  mux select MSB
- busy  out  1  high while a frame is in progress
- sample  out  4  last completed frame, bit i = y captured on channel i
- sample_valid  out  1  one-cycle pulse when sample updates

Behaviour:
- Reset values:
  - s1=s0=0, busy=0, sample=4'b0000, sample_valid=0.
  - Internal: state=IDLE, ch=0, cnt=0, mask_q=0, shadow=0.
  - Reset takes priority over every other input. Reset mid-frame aborts the frame: no sample_valid, sample keeps its reset value 0.
- States:
  - IDLE, SCAN.
  - {s1,s0} always equals the registered ch. In IDLE they hold the last channel visited.
- IDLE:
  - start=1 with en_mask!=0 at an edge: mask_q<=en_mask, shadow<=0, ch<=lowest set bit of en_mask, cnt<=0, busy<=1, state<=SCAN.
  - start=1 with en_mask==0: ignored, nothing changes.
- SCAN, every edge:
  - If cnt!=DWELL-1: cnt<=cnt+1.
  - Otherwise capture y into shadow[ch], then:
    - If a higher enabled bit exists in mask_q: ch<=next higher set bit, cnt<=0.
    - Otherwise (frame end): sample<=shadow with bit ch replaced by y; disabled channel bits are 0. sample_valid<=1 for exactly one cycle.
      - If cont=1 and en_mask!=0: relatch mask_q<=en_mask, shadow<=0, ch<=lowest set bit, cnt<=0, stay in SCAN, busy stays 1.
      - Otherwise: state<=IDLE, busy<=0.
- start is ignored while busy=1.
- en_mask changes during a frame have no effect until the next frame start.
- Timing:
  - With N enabled channels, a frame occupies N*DWELL cycles.
  - The select reaches channel k at an edge; y is sampled at the DWELL-th edge after that. Setup time for the mux is therefore DWELL-1 full cycles plus one.
  - sample and sample_valid are registered and appear in the cycle after the final capture edge.
  - busy falls on the same edge that sample_valid rises, unless the scan is continuing.
- Single-channel mask: one dwell period, then frame end.
- DWELL=1: a new channel every cycle and y sampled every cycle.

Test Plan:
- Reset: hold rst=1 for 2 cycles while start=1, en_mask=4'hF -> s1=s0=0, busy=0, sample=0000, sample_valid=0 throughout.
- Full scan, DWELL=4: mux model with a0=0, a1=1, a2=0, a3=1, en_mask=1111, pulse start.
  - {s1,s0} must be 00,01,10,11, each for 4 cycles.
  - busy=1 for 16 cycles.
  - sample=4'b1010 with sample_valid high for exactly 1 cycle.
  - Selects then hold at 11 in IDLE.
- Sparse mask: en_mask=0101, a0=1, a2=1, a1=a3=1.
  - Selects visit only 00 then 10, 4 cycles each.
  - sample=4'b0101 after 8 cycles; bits 1 and 3 are 0 despite a1=a3=1.
- Ignored starts:
  - start with en_mask=0000 -> busy stays 0, no sample_valid.
  - A start pulse 5 cycles into a 16-cycle frame -> no restart; frame ends at cycle 16 exactly once.
- Continuous mode: cont=1, en_mask=1111, toggle a-inputs between frames.
  - sample_valid pulses every 16 cycles with the new values; busy never drops.
  - Deassert cont mid-frame -> current frame completes, busy falls, no further pulses.
- Reset mid-frame: assert rst at cycle 6 of a full scan.
  - Next edge: busy=0, s1=s0=0, sample=0000; no sample_valid ever appears for the aborted frame.
  - A subsequent start scans normally.
